// File: rtl/sample_ram_pkg.sv
// Shared types and defaults for the sample RAM sequencer.
// The frame-region states and sample/address types are common to the top and its read port.
package sample_ram_pkg;

  localparam int N_SAMPLES_DEF = 784;
  localparam int ADDR_W_DEF    = 10;
  localparam int DATA_W_DEF    = 32;

  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, RUN} seq_state_t;

  typedef logic signed [DATA_W_DEF-1:0] sample_t;
  typedef logic        [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/sample_rd_port.sv
// Engine read port: one-cycle registered valid/data return plus the sticky
// out-of-range address flag.
module sample_rd_port
  import sample_ram_pkg::*;
#(
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_en,
  input  logic                     oob_clr,
  input  logic                     rd_req,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [ADDR_W-1:0]        ram_rdaddr,
  input  logic signed [DATA_W-1:0] ram_rddata,
  output logic                     rd_vld,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     err_oob
);

  localparam logic [ADDR_W:0] N_LIM = (ADDR_W+1)'(N_SAMPLES);

  logic                     fire;
  logic                     oob;
  logic                     rd_vld_d, rd_vld_q;
  logic                     err_oob_d, err_oob_q;
  logic signed [DATA_W-1:0] rd_data_d, rd_data_q;

  // The RAM latches its output on the negedge between request and capture edge.
  assign ram_rdaddr = rst_n ? rd_addr : '0;

  always_comb begin
    fire      = rd_en && rd_req;
    oob       = {1'b0, rd_addr} >= N_LIM;
    rd_vld_d  = fire;
    rd_data_d = rd_data_q;
    if (fire) begin
      rd_data_d = oob ? '0 : ram_rddata;
    end
    err_oob_d = err_oob_q;
    if (oob_clr) begin
      err_oob_d = 1'b0;
    end else if (fire && oob) begin
      err_oob_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
      err_oob_q <= 1'b0;
    end else begin
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
      err_oob_q <= err_oob_d;
    end
  end

  assign rd_vld  = rd_vld_q;
  assign rd_data = rd_data_q;
  assign err_oob = err_oob_q;

endmodule

// File: rtl/sample_ram_sequencer.sv
// Frame sequencer for the 1024x32 sample RAM: zero-fill, pixel load, engine
// hand-off, wait for done. Write path and FSM live here; reads in sample_rd_port.
module sample_ram_sequencer
  import sample_ram_pkg::*;
#(
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     start_load,
  input  logic                     abort,
  input  logic                     pix_valid,
  input  logic signed [DATA_W-1:0] pix_data,
  output logic                     pix_ready,
  output logic                     eng_start,
  input  logic                     eng_rd_req,
  input  logic [ADDR_W-1:0]        eng_rd_addr,
  output logic                     eng_rd_valid,
  output logic signed [DATA_W-1:0] eng_rd_data,
  input  logic                     eng_done,
  output logic                     busy,
  output logic                     err_oob,
  output logic                     ram_wren,
  output logic [ADDR_W-1:0]        ram_wraddr,
  output logic signed [DATA_W-1:0] ram_wrdata,
  output logic [ADDR_W-1:0]        ram_rdaddr,
  input  logic signed [DATA_W-1:0] ram_rddata
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_SAMPLES - 1);

  seq_state_t               state_d, state_q;
  logic [ADDR_W-1:0]        cnt_d, cnt_q;
  logic [ADDR_W-1:0]        wraddr_d, wraddr_q;
  logic signed [DATA_W-1:0] wrdata_d, wrdata_q;
  logic                     wren_d, wren_q;
  logic                     pix_ready_d, pix_ready_q;
  logic                     eng_start_d, eng_start_q;
  logic                     busy_d, busy_q;
  logic                     accept;
  logic                     oob_clr;
  logic                     rd_en;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wren_d      = 1'b0;
    wraddr_d    = wraddr_q;
    wrdata_d    = wrdata_q;
    pix_ready_d = 1'b0;
    eng_start_d = 1'b0;
    oob_clr     = 1'b0;
    accept      = pix_valid && pix_ready_q && (state_q == LOAD) && !abort;

    // abort overrides everything; partial frame contents stay in the RAM
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_load) begin
            state_d  = CLEAR;
            cnt_d    = '0;
            wren_d   = 1'b1;
            wraddr_d = '0;
            wrdata_d = '0;
            oob_clr  = 1'b1;
          end
        end
        CLEAR: begin
          if (cnt_q == LAST) begin
            state_d     = LOAD;
            cnt_d       = '0;
            pix_ready_d = 1'b1;
          end else begin
            cnt_d    = cnt_q + 1'b1;
            wren_d   = 1'b1;
            wraddr_d = cnt_q + 1'b1;
            wrdata_d = '0;
          end
        end
        LOAD: begin
          pix_ready_d = 1'b1;
          if (accept) begin
            wren_d   = 1'b1;
            wraddr_d = cnt_q;
            wrdata_d = pix_data;
            // counter stops at LAST so no address past the frame is ever written
            if (cnt_q == LAST) begin
              state_d     = RUN;
              pix_ready_d = 1'b0;
              eng_start_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        RUN: begin
          if (eng_done) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
    rd_en  = (state_q == RUN) && !abort;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wren_q      <= 1'b0;
      wraddr_q    <= '0;
      wrdata_q    <= '0;
      pix_ready_q <= 1'b0;
      eng_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wren_q      <= wren_d;
      wraddr_q    <= wraddr_d;
      wrdata_q    <= wrdata_d;
      pix_ready_q <= pix_ready_d;
      eng_start_q <= eng_start_d;
      busy_q      <= busy_d;
    end
  end

  assign ram_wren   = wren_q;
  assign ram_wraddr = wraddr_q;
  assign ram_wrdata = wrdata_q;
  assign pix_ready  = pix_ready_q;
  assign eng_start  = eng_start_q;
  assign busy       = busy_q;

  sample_rd_port #(
    .N_SAMPLES (N_SAMPLES),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W)
  ) u_rd_port (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .rd_en      (rd_en),
    .oob_clr    (oob_clr),
    .rd_req     (eng_rd_req),
    .rd_addr    (eng_rd_addr),
    .ram_rdaddr (ram_rdaddr),
    .ram_rddata (ram_rddata),
    .rd_vld     (eng_rd_valid),
    .rd_data    (eng_rd_data),
    .err_oob    (err_oob)
  );

endmodule

// File: tb/tb_sample_ram_sequencer.sv
// Directed bench for sample_ram_sequencer with a behavioural negedge-read RAM
// and a write-stream monitor that knows the expected zero-fill/pixel sequence.
module tb_sample_ram_sequencer;

  localparam int N = 784;

  logic               Clk = 1'b0;
  logic               Reset_n = 1'b1;
  logic               start_load = 1'b0;
  logic               abort = 1'b0;
  logic               pix_valid = 1'b0;
  logic signed [31:0] pix_data = '0;
  logic               pix_ready;
  logic               eng_start;
  logic               eng_rd_req = 1'b0;
  logic [9:0]         eng_rd_addr = '0;
  logic               eng_rd_valid;
  logic signed [31:0] eng_rd_data;
  logic               eng_done = 1'b0;
  logic               busy;
  logic               err_oob;
  logic               ram_wren;
  logic [9:0]         ram_wraddr;
  logic signed [31:0] ram_wrdata;
  logic [9:0]         ram_rdaddr;
  logic signed [31:0] ram_rddata = '0;

  logic signed [31:0] mem [1024];
  bit                 written [1024];

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  bit  mon_rst = 1'b0;
  int  wr_n, wr_bad, es_n, es_cyc, sl_cyc;

  sample_ram_sequencer dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .start_load   (start_load),
    .abort        (abort),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_ready    (pix_ready),
    .eng_start    (eng_start),
    .eng_rd_req   (eng_rd_req),
    .eng_rd_addr  (eng_rd_addr),
    .eng_rd_valid (eng_rd_valid),
    .eng_rd_data  (eng_rd_data),
    .eng_done     (eng_done),
    .busy         (busy),
    .err_oob      (err_oob),
    .ram_wren     (ram_wren),
    .ram_wraddr   (ram_wraddr),
    .ram_wrdata   (ram_wrdata),
    .ram_rdaddr   (ram_rdaddr),
    .ram_rddata   (ram_rddata)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // RAM model: write on posedge, read data registered on negedge
  always @(posedge Clk) begin
    if (ram_wren) begin
      mem[ram_wraddr]     <= ram_wrdata;
      written[ram_wraddr] <= 1'b1;
    end
  end

  always @(negedge Clk) begin
    ram_rddata <= written[ram_rdaddr] ? mem[ram_rdaddr] : 32'sh0000_7777;
  end

  // Expected stream: N zero writes at 0..N-1, then pixel k = k-392 at address k
  always @(negedge Clk) begin
    int ea, ed;
    if (mon_rst) begin
      wr_n   <= 0;
      wr_bad <= 0;
      es_n   <= 0;
      es_cyc <= 0;
    end else begin
      if (ram_wren) begin
        if (wr_n < N) begin
          ea = wr_n;
          ed = 0;
        end else begin
          ea = wr_n - N;
          ed = wr_n - N - 392;
        end
        if (int'(ram_wraddr) != ea || ram_wrdata != ed) wr_bad <= wr_bad + 1;
        wr_n <= wr_n + 1;
      end
      if (eng_start) begin
        es_n <= es_n + 1;
        if (es_n == 0) es_cyc <= cyc;
      end
    end
  end

  task automatic check(input string tag, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic mon_clear();
    @(posedge Clk); #1;
    mon_rst = 1'b1;
    @(negedge Clk); #1;
    mon_rst = 1'b0;
  endtask

  task automatic do_start();
    @(posedge Clk); #1;
    start_load = 1'b1;
    sl_cyc = cyc;
    @(posedge Clk); #1;
    start_load = 1'b0;
  endtask

  task automatic stream(input int stop_at, input bit gappy);
    int k = 0;
    int t = 0;
    int guard = 0;
    while (k < stop_at && guard < 6000) begin
      @(posedge Clk); #1;
      pix_valid = gappy ? (t % 3 == 0) : 1'b1;
      pix_data  = pix_valid ? 32'(k - 392) : 32'sh5A5A_5A5A;
      t++;
      @(negedge Clk);
      if (pix_valid && pix_ready) k++;
      guard++;
    end
    if (guard >= 6000) check("stream_timeout", k, stop_at);
  endtask

  task automatic rd_issue(input logic [9:0] a);
    @(posedge Clk); #1;
    eng_rd_req  = 1'b1;
    eng_rd_addr = a;
  endtask

  initial begin
    logic [9:0] rd_a [3];
    int         rd_e [3];
    rd_a = '{10'd0, 10'd1, 10'd783};
    rd_e = '{-392, -391, 391};

    // reset with random inputs
    #3 Reset_n = 1'b0;
    repeat (4) begin
      @(posedge Clk); #1;
      start_load  = 1'($urandom);
      abort       = 1'($urandom);
      pix_valid   = 1'($urandom);
      pix_data    = 32'($urandom);
      eng_rd_req  = 1'($urandom);
      eng_rd_addr = 10'($urandom_range(1, 1023));
      eng_done    = 1'($urandom);
    end
    @(negedge Clk);
    check("rst_ctrl", {pix_ready, eng_start, eng_rd_valid, busy, err_oob, ram_wren}, 0);
    check("rst_wraddr", ram_wraddr, 0);
    check("rst_wrdata", ram_wrdata, 0);
    check("rst_rdaddr", ram_rdaddr, 0);
    check("rst_rddata", eng_rd_data, 0);
    start_load = 0; abort = 0; pix_valid = 0; pix_data = 0;
    eng_rd_req = 0; eng_rd_addr = 0; eng_done = 0;
    Reset_n = 1'b1;
    repeat (5) @(negedge Clk);
    check("idle_after_rst_busy", busy, 0);
    check("idle_after_rst_wren", ram_wren, 0);

    // full frame, pix_valid always high
    mon_clear();
    do_start();
    @(negedge Clk);
    check("clear_busy", busy, 1);
    check("clear_wren", ram_wren, 1);
    stream(N, 1'b0);
    @(posedge Clk); #1;
    pix_valid = 1'b0;
    repeat (3) @(negedge Clk);
    check("frame_writes", wr_n, 2 * N);
    check("frame_seq_errs", wr_bad, 0);
    check("frame_start_cnt", es_n, 1);
    check("frame_start_lat", es_cyc - (sl_cyc + 1), 1568);
    check("run_busy", busy, 1);
    check("run_pix_ready", pix_ready, 0);

    // engine reads 0,1,783 back to back
    for (int i = 0; i < 4; i++) begin
      if (i < 3) rd_issue(rd_a[i]);
      else begin
        @(posedge Clk); #1;
        eng_rd_req = 1'b0;
      end
      @(negedge Clk);
      if (i > 0) begin
        check($sformatf("rd_vld_%0d", i - 1), eng_rd_valid, 1);
        check($sformatf("rd_data_%0d", i - 1), eng_rd_data, rd_e[i-1]);
      end
    end
    check("rd_no_oob", err_oob, 0);
    rd_issue(10'd800);
    @(posedge Clk); #1;
    eng_rd_req = 1'b0;
    @(negedge Clk);
    check("oob_vld", eng_rd_valid, 1);
    check("oob_data", eng_rd_data, 0);
    check("oob_flag", err_oob, 1);
    @(negedge Clk);
    check("oob_vld_drop", eng_rd_valid, 0);

    // start_load during RUN is ignored
    @(posedge Clk); #1;
    start_load = 1'b1;
    @(posedge Clk); #1;
    start_load = 1'b0;
    repeat (3) @(negedge Clk);
    check("sl_in_run_busy", busy, 1);
    check("sl_in_run_writes", wr_n, 2 * N);
    check("oob_sticky", err_oob, 1);

    // eng_done together with a read request
    @(posedge Clk); #1;
    eng_done = 1'b1; eng_rd_req = 1'b1; eng_rd_addr = 10'd5;
    @(posedge Clk); #1;
    eng_done = 1'b0; eng_rd_addr = 10'd3;
    @(negedge Clk);
    check("done_rd_vld", eng_rd_valid, 1);
    check("done_rd_data", eng_rd_data, 5 - 392);
    check("done_busy", busy, 0);
    @(posedge Clk); #1;
    eng_rd_req = 1'b0;
    @(negedge Clk);
    check("idle_rd_vld", eng_rd_valid, 0);
    check("idle_oob_kept", err_oob, 1);

    // abort at pixel 100 of LOAD
    mon_clear();
    do_start();
    @(negedge Clk);
    check("oob_cleared", err_oob, 0);
    stream(100, 1'b0);
    @(posedge Clk); #1;
    abort = 1'b1;
    pix_data = 32'(100 - 392);
    @(posedge Clk); #1;
    abort = 1'b0;
    pix_valid = 1'b0;
    @(negedge Clk);
    check("abort_busy", busy, 0);
    check("abort_wren", ram_wren, 0);
    check("abort_pix_ready", pix_ready, 0);
    repeat (5) @(negedge Clk);
    check("abort_writes", wr_n, N + 100);
    check("abort_seq_errs", wr_bad, 0);
    check("abort_no_start", es_n, 0);

    // fresh frame with pix_valid 1,0,0,1,...
    mon_clear();
    do_start();
    stream(N, 1'b1);
    @(posedge Clk); #1;
    pix_valid = 1'b0;
    repeat (3) @(negedge Clk);
    check("bp_writes", wr_n, 2 * N);
    check("bp_seq_errs", wr_bad, 0);
    check("bp_start_cnt", es_n, 1);
    check("bp_busy", busy, 1);

    // asynchronous reset mid-frame
    @(posedge Clk); #1;
    eng_done = 1'b1;
    @(posedge Clk); #1;
    eng_done = 1'b0;
    do_start();
    repeat (5) @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_wren", ram_wren, 0);
    #10 Reset_n = 1'b1;
    @(negedge Clk);
    check("post_rst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before 1ms");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sample_ram_sequencer.md
Name: sample_ram_sequencer

Overview:
- Owns both ports of the 1024x32 signed sample RAM that holds one input image for the digit-recognition network.
- Sequences a frame in four steps: zero-fill the frame region, stream N_SAMPLES pixels in, hand the read port to the inference engine, then wait for the engine to finish.
- Sits between the pixel source (drawing/capture logic) and the first-layer inference engine.
- Guarantees the engine never reads a partially written frame.

Parameters:
N_SAMPLES, 784, samples per frame (28x28); legal range 1..1024
ADDR_W, 10, RAM address width
DATA_W, 32, sample width (signed)

Ports:
Clk  in  1  system clock; all logic on posedge
Reset_n  in  1  asynchronous, active-low reset
start_load  in  1  one-cycle request to begin a new frame
abort  in  1  return to IDLE immediately; no engine start
pix_valid  in  1  pixel source has data
pix_data  in  DATA_W  signed pixel value
pix_ready  out  1  sequencer accepts pixel this cycle
eng_start  out  1  one-cycle pulse: frame is complete and stable
eng_rd_req  in  1  engine read request
eng_rd_addr  in  ADDR_W  engine read address
eng_rd_valid  out  1  eng_rd_data is valid
eng_rd_data  out  DATA_W  returned sample
eng_done  in  1  engine has finished with the frame
busy  out  1  high in any state other than IDLE
err_oob  out  1  sticky: engine read address >= N_SAMPLES; cleared by start_load
ram_wren  out  1  RAM write enable
ram_wraddr  out  ADDR_W  RAM write address
ram_wrdata  out  DATA_W  RAM write data
ram_rdaddr  out  ADDR_W  RAM read address
ram_rddata  in  DATA_W  RAM read data; the RAM registers it on negedge Clk

Behaviour:
- Reset: state=IDLE, write counter=0, and every output 0 (pix_ready, eng_start, eng_rd_valid, eng_rd_data, busy, err_oob, ram_wren, ram_wraddr, ram_wrdata, ram_rdaddr).
- All RAM write signals are registered.

State machine:
- IDLE: start_load -> CLEAR, counter=0, err_oob cleared.
- CLEAR: ram_wren=1, wrdata=0, wraddr=counter, one word per cycle. After address N_SAMPLES-1 is written -> LOAD, counter=0. Takes exactly N_SAMPLES cycles.
- LOAD: pix_ready=1. On pix_valid&&pix_ready, write pix_data at counter and increment counter. After the N_SAMPLES-th accepted pixel -> RUN; pix_ready drops the same edge. Gaps in pix_valid stall the counter.
- RUN: eng_start pulses on the first cycle of RUN only. Engine owns the read port. eng_done -> IDLE.

Engine read path:
- ram_rdaddr follows eng_rd_addr combinationally.
- eng_rd_valid is eng_rd_req registered one posedge later.
- eng_rd_data is ram_rddata sampled on that posedge (RAM updates on the intervening negedge). Fixed latency: 1 cycle. One request per cycle sustained.
- Reads are honoured only in RUN. A request outside RUN yields eng_rd_valid=0.
- eng_rd_addr >= N_SAMPLES in RUN: eng_rd_valid=1, eng_rd_data=0, err_oob set.

Boundary conditions:
- start_load outside IDLE: ignored.
- eng_done outside RUN: ignored.
- abort in any state: -> IDLE next edge. ram_wren deasserts that edge; partial frame contents are left in place. abort has priority over every other input.
- eng_done and eng_rd_req in the same cycle: the read is still returned (eng_rd_valid=1 the next cycle, in IDLE); state -> IDLE.
- start_load and eng_done in the same cycle while in RUN: go to IDLE only; start_load is not latched.
- Counter never wraps. Addresses at or above N_SAMPLES are never written.
- Reset_n asserted mid-frame: immediate return to reset values. RAM contents are undefined to the engine until the next eng_start.

Decomposition:
- Package sample_ram_pkg:
  - typedef seq_state_t {IDLE, CLEAR, LOAD, RUN}
  - localparam N_SAMPLES_DEF=784
  - sample_t (signed DATA_W)
  - addr_t (ADDR_W)
- Sub-module: sample_rd_port, holding the 1-cycle valid/data return pipeline and the OOB check. The FSM and write path stay in the top.

Test Plan:
- Reset: hold Reset_n=0 with random inputs -> all outputs 0, busy=0. Release -> stays IDLE until start_load.
- Full frame: start_load; pixel k=k-392 streamed with pix_valid always 1 -> 784 zero writes, then 784 writes with wraddr=k and wrdata=k-392; eng_start is one pulse exactly 1568 cycles after the cycle following start_load.
- Backpressure: pix_valid toggled 1,0,0,1,... -> write count still exactly 784, addresses contiguous, no write on idle cycles.
- Engine reads: in RUN, eng_rd_addr 0,1,783 on consecutive cycles -> eng_rd_valid on the next three cycles, data -392,-391,391. Addr 800 -> data 0, err_oob=1 and stays 1 until the next start_load.
- Abort: abort at pixel 100 of LOAD -> IDLE next cycle, no eng_start, ram_wren=0; a fresh start_load then runs the full CLEAR again.
- Collisions: start_load during RUN ignored. eng_done with eng_rd_req in the same cycle -> eng_rd_valid 1 cycle later, state IDLE, busy=0.
